// File: rtl/dynamic_segmented_adder.sv
`default_nettype none
// =============================================================================
// Module      : dynamic_segmented_adder
// Description : Variable-latency segmented adder with valid/ready handshake;
//               carries ripple one segment per cycle only across propagate runs.
// Revision    : 1.0 - initial release
// =============================================================================
module dynamic_segmented_adder #(
    parameter int N     = 16,
    parameter int SEG_W = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [N-1:0]                  A,
    input  logic [N-1:0]                  B,
    input  logic                          Cin,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [N-1:0]                  S,
    output logic                          Cout,
    output logic [N-1:0]                  P,
    output logic [$clog2(N/SEG_W+2)-1:0]  lat
);

    localparam int NSEG  = N / SEG_W;
    localparam int LAT_W = $clog2(NSEG + 2);
    localparam logic [LAT_W-1:0] c_lat_one = LAT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;

    logic [N-1:0]       r_a;
    logic [N-1:0]       r_b;
    logic [N-1:0]       r_p;
    logic [N-1:0]       r_s;
    logic               r_cout;
    logic [LAT_W-1:0]   r_lat;
    logic [LAT_W-1:0]   r_cnt;
    logic [NSEG:0]      r_known;
    logic [NSEG:0]      r_cin;

    logic [NSEG-1:0]    w_in_gen;
    logic [NSEG-1:0]    w_in_prop;
    logic [NSEG-1:0]    w_prop;
    logic [N-1:0]       w_sum;
    logic [NSEG:0]      w_known_init;
    logic [NSEG:0]      w_cin_init;
    logic [NSEG:0]      w_known_adv;
    logic [NSEG:0]      w_cin_adv;
    logic               w_all_known;

    // Per-segment generate/propagate from the incoming operands, and the
    // final segment sums from the registered operands and resolved carries.
    genvar gs;
    generate
        for (gs = 0; gs < NSEG; gs++) begin : g_seg
            logic [SEG_W-1:0] w_a_in;
            logic [SEG_W-1:0] w_b_in;
            assign w_a_in        = A[gs*SEG_W +: SEG_W];
            assign w_b_in        = B[gs*SEG_W +: SEG_W];
            // a + b overflows the segment exactly when a > (2^W - 1 - b) = ~b
            assign w_in_gen[gs]  = (w_a_in > ~w_b_in);
            assign w_in_prop[gs] = &(w_a_in ^ w_b_in);
            assign w_prop[gs]    = &r_p[gs*SEG_W +: SEG_W];
            assign w_sum[gs*SEG_W +: SEG_W] = r_a[gs*SEG_W +: SEG_W]
                                            + r_b[gs*SEG_W +: SEG_W]
                                            + {{(SEG_W-1){1'b0}}, r_cin[gs]};
        end
    endgenerate

    always_comb begin
        w_known_init    = '0;
        w_cin_init      = '0;
        w_known_init[0] = 1'b1;
        w_cin_init[0]   = Cin;
        for (int s = 1; s <= NSEG; s++) begin
            w_known_init[s] = ~w_in_prop[s-1];
            w_cin_init[s]   = w_in_gen[s-1];
        end
    end

    // Uses the previous cycle's known[] so a carry moves one segment per cycle.
    always_comb begin
        w_known_adv = r_known;
        w_cin_adv   = r_cin;
        for (int s = 1; s <= NSEG; s++) begin
            if (!r_known[s] && r_known[s-1] && w_prop[s-1]) begin
                w_known_adv[s] = 1'b1;
                w_cin_adv[s]   = r_cin[s-1];
            end
        end
    end

    assign w_all_known = &r_known;

    always_comb begin
        w_next_state = r_state;
        if (enable) begin
            case (r_state)
                ST_IDLE:    if (in_valid)    w_next_state = ST_COMPUTE;
                ST_COMPUTE: if (w_all_known) w_next_state = ST_DONE;
                ST_DONE:    if (out_ready)   w_next_state = ST_IDLE;
                default:                     w_next_state = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_p     <= '0;
            r_s     <= '0;
            r_cout  <= 1'b0;
            r_lat   <= '0;
            r_cnt   <= '0;
            r_known <= '0;
            r_cin   <= '0;
        end else if (enable) begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a     <= A;
                        r_b     <= B;
                        r_p     <= A ^ B;
                        r_known <= w_known_init;
                        r_cin   <= w_cin_init;
                        r_cnt   <= c_lat_one;
                    end
                end
                ST_COMPUTE: begin
                    if (w_all_known) begin
                        r_s    <= w_sum;
                        r_cout <= r_cin[NSEG];
                        r_lat  <= r_cnt;
                    end else begin
                        r_known <= w_known_adv;
                        r_cin   <= w_cin_adv;
                        r_cnt   <= r_cnt + c_lat_one;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign S         = r_s;
    assign Cout      = r_cout;
    assign P         = r_p;
    assign lat       = r_lat;

endmodule
`default_nettype wire

// File: tb/tb_dynamic_segmented_adder.sv
`default_nettype none
// Testbench for dynamic_segmented_adder: directed vector table, handshake and
// reset corner sequences, then biased random ops against an arithmetic model.
module tb_dynamic_segmented_adder;

    localparam int N         = 16;
    localparam int SEG_W     = 4;
    localparam int NSEG      = N / SEG_W;
    localparam int LAT_W     = $clog2(NSEG + 2);
    localparam int NUM_RAND  = 5000;
    localparam int MAX_WAIT  = 200;

    logic             clk = 1'b0;
    logic             rst;
    logic             enable;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     A;
    logic [N-1:0]     B;
    logic             Cin;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     S;
    logic             Cout;
    logic [N-1:0]     P;
    logic [LAT_W-1:0] lat;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dynamic_segmented_adder #(.N(N), .SEG_W(SEG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .Cout      (Cout),
        .P         (P),
        .lat       (lat)
    );

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         cin;
        logic [N-1:0] s;
        logic         cout;
        logic [N-1:0] p;
        int           lat;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic finish_run;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: no response after %0d cycles, expected handshake", name, MAX_WAIT);
        finish_run();
    endtask

    // Latency model: 1 + longest run of segments whose bits all propagate.
    function automatic int model_lat(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N-1:0] x;
        int run;
        int best;
        x = a ^ b;
        run = 0;
        best = 0;
        for (int s = 0; s < NSEG; s++) begin
            if (&x[s*SEG_W +: SEG_W]) run++;
            else run = 0;
            if (run > best) best = run;
        end
        return 1 + best;
    endfunction

    task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b,
                            input logic cin, input bit rnd);
        A = a;
        B = b;
        Cin = cin;
        in_valid = 1'b1;
        for (int i = 0; i < MAX_WAIT; i++) begin
            bit acc;
            enable = rnd ? ($urandom_range(0, 7) != 0) : 1'b1;
            acc = in_ready && enable;
            @(negedge clk);
            if (acc) begin
                in_valid = 1'b0;
                A = N'($urandom);
                B = N'($urandom);
                Cin = 1'($urandom);
                enable = 1'b1;
                return;
            end
        end
        timeout_fail("accept");
    endtask

    task automatic wait_valid(input bit rnd, output int ncyc);
        ncyc = 0;
        for (int i = 0; i < MAX_WAIT; i++) begin
            if (out_valid) return;
            enable = rnd ? ($urandom_range(0, 7) != 0) : 1'b1;
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            if (enable) ncyc++;
            @(negedge clk);
        end
        timeout_fail("out_valid");
    endtask

    task automatic consume(input bit rnd);
        logic [N-1:0] s0;
        logic         c0;
        s0 = S;
        c0 = Cout;
        for (int i = 0; i < MAX_WAIT; i++) begin
            bit acc;
            out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            enable = rnd ? ($urandom_range(0, 7) != 0) : 1'b1;
            acc = out_ready && enable;
            check("hold", {15'd0, out_valid, Cout, S}, {15'd0, 1'b1, c0, s0});
            @(negedge clk);
            if (acc) begin
                out_ready = 1'b0;
                enable = 1'b1;
                check("idle_after_consume", {30'd0, in_ready, out_valid}, 32'b10);
                return;
            end
        end
        timeout_fail("consume");
    endtask

    task automatic run_op(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic cin, input logic [N-1:0] es, input logic ec,
                          input logic [N-1:0] ep, input int el, input bit rnd);
        int n;
        start_op(a, b, cin, rnd);
        wait_valid(rnd, n);
        check({name, ".S"},    {16'd0, S},       {16'd0, es});
        check({name, ".Cout"}, {31'd0, Cout},    {31'd0, ec});
        check({name, ".P"},    {16'd0, P},       {16'd0, ep});
        check({name, ".lat"},  32'(lat),         32'(el));
        check({name, ".cyc"},  32'(n),           32'(el));
        consume(rnd);
    endtask

    initial begin
        int n;
        logic [N-1:0] s_hold;

        vecs[0] = '{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 16'h0000, 1};
        vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 16'hFFFF, 5};
        vecs[2] = '{16'h0F0F, 16'h00F0, 1'b1, 16'h1000, 1'b0, 16'h0FFF, 4};
        vecs[3] = '{16'h0F0F, 16'h00F0, 1'b0, 16'h0FFF, 1'b0, 16'h0FFF, 4};
        vecs[4] = '{16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 16'hFFFF, 5};
        vecs[5] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 16'hFFFE, 4};
        vecs[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 16'h0000, 1};
        vecs[7] = '{16'hF0F0, 16'h0000, 1'b1, 16'hF0F1, 1'b0, 16'hF0F0, 2};

        rst = 1'b1;
        enable = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        A = '0;
        B = '0;
        Cin = 1'b0;
        repeat (3) @(negedge clk);
        check("reset.hs", {30'd0, in_ready, out_valid}, 32'b10);
        check("reset.out", {Cout, S, lat, P[12:0]}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_reset.P", {16'd0, P}, 32'd0);

        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
                   vecs[i].s, vecs[i].cout, vecs[i].p, vecs[i].lat, 1'b0);
        end

        // Back-pressure: result held while out_ready stays low.
        start_op(16'hFFFF, 16'h0000, 1'b1, 1'b0);
        wait_valid(1'b0, n);
        check("bp.lat", 32'(lat), 32'd5);
        for (int i = 0; i < 10; i++) begin
            out_ready = 1'b0;
            @(negedge clk);
            check("bp.hold", {14'd0, out_valid, in_ready, Cout, S}, {14'd0, 1'b1, 1'b0, 1'b1, 16'h0000});
        end
        consume(1'b0);
        run_op("after_bp", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 16'h0000, 1, 1'b0);

        // Enable stall during compute: cycle count covers enabled cycles only.
        start_op(16'hFFFF, 16'h0000, 1'b1, 1'b0);
        enable = 1'b0;
        repeat (4) @(negedge clk);
        check("stall.frozen", {30'd0, in_ready, out_valid}, 32'b00);
        wait_valid(1'b0, n);
        check("stall.lat", 32'(lat), 32'd5);
        check("stall.cyc", 32'(n), 32'd5);
        consume(1'b0);

        // Async reset mid-compute aborts; previous S was nonzero.
        run_op("pre_rst", 16'h0F0F, 16'h00F0, 1'b0, 16'h0FFF, 1'b0, 16'h0FFF, 4, 1'b0);
        start_op(16'hFFFF, 16'h0000, 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid.hs", {30'd0, in_ready, out_valid}, 32'b10);
        s_hold = S;
        check("rst_mid.S", {16'd0, s_hold}, 32'd0);
        check("rst_mid.P", {16'd0, P}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op("after_rst", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 16'h0000, 1, 1'b0);

        for (int k = 0; k < NUM_RAND; k++) begin
            logic [N-1:0] a;
            logic [N-1:0] b;
            logic         cin;
            logic [N:0]   tot;
            a = N'($urandom);
            b = N'($urandom);
            for (int s = 0; s < NSEG; s++) begin
                if ($urandom_range(0, 1) == 1) b[s*SEG_W +: SEG_W] = ~a[s*SEG_W +: SEG_W];
            end
            cin = 1'($urandom);
            tot = {1'b0, a} + {1'b0, b} + (N+1)'(cin);
            run_op("rand", a, b, cin, tot[N-1:0], tot[N], a ^ b, model_lat(a, b), 1'b1);
        end

        finish_run();
    end

endmodule
`default_nettype wire
